hawk_video_temp_extract: RTL
============================

HAWK_VIDEO_TEMP_EXTRACT -- requirements
Module: hawk_video_temp_extract

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SIZE_X, 640, active pixels per line.
- SIZE_Y, 480, active lines per frame.
- FILL, 16'h0000, value substituted for the temperature beat on the output stream.

REQ-002 Ports, one per line: name, direction, width, meaning.
- stream_clk, in, 1, single clock; all logic is on its rising edge.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, 1 = extract/check; 0 = transparent pass-through.
- stream_in_sop / stream_in_valid / stream_in_eop, in, 1 each, upstream stream framing.
- stream_in_data, in, 16, upstream stream data.
- stream_out_sop / stream_out_valid / stream_out_eop, out, 1 each, downstream stream framing.
- stream_out_data, out, 16, downstream stream data.
- temp_out, out, 16, last captured temperature word.
- temp_valid, out, 1, 1-cycle strobe when temp_out updates.
- pix_x, out, 10, column of the current output pixel beat.
- pix_y, out, 9, line of the current output pixel beat.
- pix_min / pix_max, out, 16 each, extremes of the last good frame.
- frame_done, out, 1, 1-cycle strobe at the end of a good frame.
- frame_err, out, 1, sticky error flag; cleared at the next sop.
- err_count, out, 16, saturating count of bad frames.

Function
REQ-003 Frame format: sop beat (header, valid=1) -> temperature beat (first valid non-sop beat) -> SIZE_X*SIZE_Y pixel beats; the last pixel beat carries eop.
REQ-004 All stream outputs SHALL be registered: input beat at cycle n appears at cycle n+1; valid/sop/eop are delayed unchanged.
REQ-005 Output data on the temperature beat SHALL be FILL; data on all other beats SHALL pass through unchanged.
REQ-006 FSM states and transitions:
- IDLE -> TEMP on a valid sop.
- TEMP -> PIX on a valid non-sop beat; temp_out <= data; temp_valid pulses, aligned with the output beat.
- PIX counts beats.
- DRAIN is entered on error and exits to TEMP on the next sop.
REQ-007 Valid sop in TEMP or PIX SHALL flag a short-frame error, count it, and restart in TEMP.
REQ-008 eop in PIX with pixel index != SIZE_X*SIZE_Y-1 SHALL flag an error and go to IDLE.
REQ-009 A pixel beat at index SIZE_X*SIZE_Y-1 without eop SHALL flag an error and go to DRAIN.
REQ-010 eop on the temperature beat SHALL flag an error and go to IDLE.
REQ-011 Beats with valid=0 SHALL be ignored by the FSM and counters.
REQ-012 pix_x/pix_y SHALL advance per output pixel beat and wrap: x wraps SIZE_X-1 -> 0 and increments y; both read 0 at the sop and temperature beats.
REQ-013 Running min/max over pixel beats only:
- The temperature beat is excluded.
- Running min/max are initialised from pixel 0.
- On a correct eop, running values are copied to pix_min/pix_max and frame_done pulses, aligned with stream_out_eop.
- Errored frames SHALL NOT update pix_min/pix_max.
REQ-014 frame_err SHALL set in the cycle after the error beat and clear in the cycle the next sop is output.
REQ-015 err_count SHALL increment once per bad frame and saturate at 16'hFFFF.
REQ-016 With enable=0:
- FSM forced to IDLE; no substitution, strobes, or stats updates.
- Stream still delayed by 1 cycle.
- Deasserting enable mid-frame drops the frame without error.
REQ-017 Simultaneous sop+eop on one beat in PIX SHALL be handled as an error on the current frame plus the start of a new frame.

Reset
REQ-018 reset SHALL clear the following to 0: all stream outputs, temp_out, temp_valid, pix_x, pix_y, pix_min, pix_max, frame_done, frame_err, err_count; FSM -> IDLE.
REQ-019 Reset asserted mid-frame SHALL discard the frame with no error counted; the next frame needs a fresh sop.

Structure
REQ-020 Shared package hawk_video_pkg SHALL hold SIZE_X/SIZE_Y defaults, the FSM state type, and the pixel/line counter widths.
REQ-021 Min/max tracking SHALL be a sub-module hawk_video_minmax (inputs: start, sample, valid, commit; outputs: min, max).

Verification (SIZE_X=4, SIZE_Y=2)
REQ-022 sop, T=16'h1234, pixels 1..8 with eop on 8 ->
- output: sop, FILL, 1..8;
- temp_out=1234 with temp_valid pulsed;
- pix_min=1, pix_max=8, frame_done at eop; frame_err=0.
REQ-023 Same frame with a 2-cycle valid gap after pixel 3 -> identical output beats, pix_x/pix_y sequence unchanged, no error.
REQ-024 eop on pixel 6 -> frame_err=1, err_count=1, pix_min/pix_max unchanged, no frame_done.
REQ-025 9 pixels, no eop on pixel 8 -> error at pixel 8, DRAIN until next sop; the following good frame updates stats and clears frame_err.
REQ-026 reset asserted at pixel 4, then a good frame -> all outputs 0 after reset, err_count=0, next frame processed normally.
REQ-027 enable=0 with a frame of T=16'hABCD -> output data contains ABCD unchanged, no temp_valid, no frame_done.

Source files
------------

// File: rtl/hawk_video_pkg.sv
// Shared definitions for the hawk video temperature-extract slice.
//   SIZE_X_DEF / SIZE_Y_DEF : default active frame geometry
//   X_W / Y_W               : widths of the column / line counters
//   state_t, ST_*           : frame-parser FSM encoding
package hawk_video_pkg;

    localparam int SIZE_X_DEF = 640;
    localparam int SIZE_Y_DEF = 480;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;  // waiting for a sop
    localparam logic [1:0] ST_TEMP  = 2'd1;  // next data beat is the temperature word
    localparam logic [1:0] ST_PIX   = 2'd2;  // counting pixel beats
    localparam logic [1:0] ST_DRAIN = 2'd3;  // frame overran, discard until sop

endpackage

// File: rtl/hawk_video_minmax.sv
// Running minimum / maximum tracker for one frame of pixel samples.
//   stream_clk : clock, rising edge
//   reset      : synchronous active-high reset
//   start      : current sample is the first of the frame (re-seeds running values)
//   sample     : pixel value
//   valid      : sample is a pixel beat
//   commit     : current sample is the last of a good frame; publish results
//   min / max  : extremes of the last committed frame
module hawk_video_minmax #(
    parameter int W = 16
) (
    input  logic         stream_clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] sample,
    input  logic         valid,
    input  logic         commit,
    output logic [W-1:0] min,
    output logic [W-1:0] max
);

    logic [W-1:0] run_min;
    logic [W-1:0] run_max;
    logic [W-1:0] nxt_min;
    logic [W-1:0] nxt_max;

    // The committing beat is itself a pixel, so the published value must
    // already include it rather than the one-beat-stale running register.
    assign nxt_min = (start || sample < run_min) ? sample : run_min;
    assign nxt_max = (start || sample > run_max) ? sample : run_max;

    always_ff @(posedge stream_clk) begin
        if (reset) begin
            run_min <= '0;
            run_max <= '0;
            min     <= '0;
            max     <= '0;
        end else if (valid) begin
            run_min <= nxt_min;
            run_max <= nxt_max;
            if (commit) begin
                min <= nxt_min;
                max <= nxt_max;
            end
        end
    end

endmodule

// File: rtl/hawk_video_temp_extract.sv
// Video stream temperature-word extractor and frame checker.
// Each frame is: sop header, one temperature beat, SIZE_X*SIZE_Y pixels
// (eop on the last). The stream is re-registered with one cycle latency;
// the temperature beat is replaced by FILL and captured on temp_out.
//   stream_clk, reset, enable         : clock, sync reset, extract enable
//   stream_in_*  / stream_out_*       : upstream / downstream stream
//   temp_out, temp_valid              : captured temperature + update strobe
//   pix_x, pix_y                      : coordinate of the current output pixel
//   pix_min, pix_max, frame_done      : stats of the last good frame + strobe
//   frame_err, err_count              : sticky error flag, saturating bad-frame count
module hawk_video_temp_extract
    import hawk_video_pkg::*;
#(
    parameter int          SIZE_X = SIZE_X_DEF,
    parameter int          SIZE_Y = SIZE_Y_DEF,
    parameter logic [15:0] FILL   = 16'h0000
) (
    input  logic         stream_clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         stream_in_sop,
    input  logic         stream_in_valid,
    input  logic         stream_in_eop,
    input  logic [15:0]  stream_in_data,
    output logic         stream_out_sop,
    output logic         stream_out_valid,
    output logic         stream_out_eop,
    output logic [15:0]  stream_out_data,
    output logic [15:0]  temp_out,
    output logic         temp_valid,
    output logic [9:0]   pix_x,
    output logic [8:0]   pix_y,
    output logic [15:0]  pix_min,
    output logic [15:0]  pix_max,
    output logic         frame_done,
    output logic         frame_err,
    output logic [15:0]  err_count
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SIZE_X - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SIZE_Y - 1);

    state_t         state;
    state_t         state_nxt;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;

    logic is_sop;      // enabled valid sop beat
    logic is_data;     // enabled valid non-sop beat
    logic last_pix;    // next pixel expected is the final one of the frame
    logic temp_beat;
    logic pix_beat;
    logic err_now;
    logic good_eop;

    assign is_sop    = enable && stream_in_valid &&  stream_in_sop;
    assign is_data   = enable && stream_in_valid && !stream_in_sop;
    assign last_pix  = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
    assign temp_beat = (state == ST_TEMP) && is_data;
    assign pix_beat  = (state == ST_PIX)  && is_data;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        err_now   = 1'b0;
        good_eop  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_sop) state_nxt = ST_TEMP;
                end
                ST_TEMP: begin
                    if (is_sop) begin
                        err_now = 1'b1;          // short frame, restart
                    end else if (is_data) begin
                        if (stream_in_eop) begin
                            err_now   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_PIX;
                        end
                    end
                end
                ST_PIX: begin
                    // A sop here (with or without eop) ends the current frame
                    // as an error and opens the next one.
                    if (is_sop) begin
                        err_now   = 1'b1;
                        state_nxt = ST_TEMP;
                    end else if (is_data) begin
                        if (stream_in_eop) begin
                            good_eop  = last_pix;
                            err_now   = !last_pix;
                            state_nxt = ST_IDLE;
                        end else if (last_pix) begin
                            err_now   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (is_sop) state_nxt = ST_TEMP;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge stream_clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt_x            <= '0;
            cnt_y            <= '0;
            stream_out_sop   <= 1'b0;
            stream_out_valid <= 1'b0;
            stream_out_eop   <= 1'b0;
            stream_out_data  <= '0;
            temp_out         <= '0;
            temp_valid       <= 1'b0;
            pix_x            <= '0;
            pix_y            <= '0;
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
            err_count        <= '0;
        end else begin
            state            <= state_nxt;
            stream_out_sop   <= stream_in_sop;
            stream_out_valid <= stream_in_valid;
            stream_out_eop   <= stream_in_eop;
            stream_out_data  <= temp_beat ? FILL : stream_in_data;

            // A temperature beat that also carries eop kills the frame, so
            // its word is not published.
            temp_valid <= temp_beat && !stream_in_eop;
            if (temp_beat && !stream_in_eop) temp_out <= stream_in_data;

            frame_done <= good_eop;

            // The error of the old frame wins over the clear when a sop both
            // aborts one frame and starts the next.
            if (err_now)     frame_err <= 1'b1;
            else if (is_sop) frame_err <= 1'b0;

            if (err_now && err_count != 16'hFFFF) err_count <= err_count + 16'd1;

            if (pix_beat) begin
                pix_x <= cnt_x;
                pix_y <= cnt_y;
                if (cnt_x == X_LAST) begin
                    cnt_x <= '0;
                    cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + 1'b1;
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end else begin
                // Coordinates hold across valid gaps, read 0 on header beats.
                if (!enable || stream_in_valid) begin
                    pix_x <= '0;
                    pix_y <= '0;
                end
                if (state != ST_PIX) begin
                    cnt_x <= '0;
                    cnt_y <= '0;
                end
            end
        end
    end

    hawk_video_minmax #(.W(16)) u_minmax (
        .stream_clk (stream_clk),
        .reset      (reset),
        .start      ((cnt_x == '0) && (cnt_y == '0)),
        .sample     (stream_in_data),
        .valid      (pix_beat),
        .commit     (good_eop),
        .min        (pix_min),
        .max        (pix_max)
    );

endmodule
